// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and elaboration helpers for the pipe drain buffer slice.
//   DEFAULT_BIT_WIDTH : default data word width
//   clog2()           : constant ceil(log2) used to size pointers and counters
//   is_pow2()         : true when a depth is a power of two and at least 2
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int DEFAULT_BIT_WIDTH = 10;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Buffer pointers wrap naturally only when the depth is a power of two.
  function automatic bit is_pow2(input int value);
    return (value >= 32'sd2) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/pipe_drain_buffer_if.sv
// -----------------------------------------------------------------------------
// pipe_drain_buffer_if
// Bundles the upstream credit handshake, the pipeline arrival port and the
// downstream valid/ready port of the drain buffer.
//   in_valid / in_ready     : launch request and credit grant
//   pipe_valid / pipe_data  : word emerging from the fixed-latency pipeline
//   out_valid / out_data / out_ready : show-ahead downstream handshake
//   level / overflow        : occupancy and sticky loss flag
// Modports: slave = the buffer, master = the surrounding logic.
// -----------------------------------------------------------------------------
interface pipe_drain_buffer_if
  import pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int DEPTH     = 8
);

  localparam int LW = clog2(DEPTH) + 32'sd1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 pipe_valid;
  logic [BIT_WIDTH-1:0] pipe_data;
  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_ready;
  logic [LW-1:0]        level;
  logic                 overflow;

  modport slave (
    input  in_valid,
    output in_ready,
    input  pipe_valid,
    input  pipe_data,
    output out_valid,
    output out_data,
    input  out_ready,
    output level,
    output overflow
  );

  modport master (
    output in_valid,
    input  in_ready,
    output pipe_valid,
    output pipe_data,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  level,
    input  overflow
  );

endinterface

// File: rtl/pipe_drain_buffer_chk.sv
// -----------------------------------------------------------------------------
// pipe_drain_buffer_chk
// Property checker for pipe_drain_buffer, attached alongside the design.
//   clk, reset_n : as the design
//   launch       : in_valid & in_ready
//   credit       : credit counter of the design
//   level        : stored word count of the design
// Tracks launches still travelling through a LATENCY-deep pipeline and checks
// credit + level + in-flight == DEPTH and 0 <= credit <= DEPTH.
// -----------------------------------------------------------------------------
module pipe_drain_buffer_chk
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 5
) (
  input logic                      clk,
  input logic                      reset_n,
  input logic                      launch,
  input logic [clog2(DEPTH):0]     credit,
  input logic [clog2(DEPTH):0]     level
);

  localparam int SR_W = (LATENCY > 32'sd0) ? LATENCY : 32'sd1;

  logic [SR_W-1:0] inflight_sr_r;
  int              inflight_cnt_s;

  // Mirror of the upstream valid delay line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_sr_r <= {SR_W{1'b0}};
    end else begin
      for (int i = SR_W - 1; i > 0; i--) begin
        inflight_sr_r[i] <= inflight_sr_r[i-1];
      end
      inflight_sr_r[0] <= launch;
    end
  end

  // Number of launches not yet written into the buffer.
  always_comb begin
    inflight_cnt_s = 32'sd0;
    for (int i = 0; i < SR_W; i++) begin
      if (inflight_sr_r[i] && (LATENCY > 32'sd0)) begin
        inflight_cnt_s = inflight_cnt_s + 32'sd1;
      end else begin
        inflight_cnt_s = inflight_cnt_s;
      end
    end
  end

  a_depth_pow2: assert property (@(posedge clk) is_pow2(DEPTH))
    else $error("pipe_drain_buffer_chk: DEPTH is not a power of two >= 2");

  a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
      int'(credit) <= DEPTH)
    else $error("pipe_drain_buffer_chk: credit out of range");

  a_conservation: assert property (@(posedge clk) disable iff (!reset_n)
      (int'(credit) + int'(level) + inflight_cnt_s) == DEPTH)
    else $error("pipe_drain_buffer_chk: credit + level + in-flight != DEPTH");

endmodule

// File: rtl/pipe_drain_ram.sv
// -----------------------------------------------------------------------------
// pipe_drain_ram
// DEPTH x BIT_WIDTH register array with one synchronous write port and one
// asynchronous read port.
//   clk, reset_n       : clock and async active-low reset (array clears to 0)
//   wr_en/wr_addr/wr_data : write port
//   rd_addr/rd_data    : combinational read port
// -----------------------------------------------------------------------------
module pipe_drain_ram
  import pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [clog2(DEPTH)-1:0]  wr_addr,
  input  logic [BIT_WIDTH-1:0]     wr_data,
  input  logic [clog2(DEPTH)-1:0]  rd_addr,
  output logic [BIT_WIDTH-1:0]     rd_data
);

  logic [BIT_WIDTH-1:0] mem_r [DEPTH];

  // Storage array: cleared on reset, written one entry per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {BIT_WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/pipe_drain_buffer.sv
// -----------------------------------------------------------------------------
// pipe_drain_buffer
// Receive-end companion for a fixed-latency, non-stallable pipeline. Credits
// gate launches upstream; every word emerging from the pipeline is caught in a
// circular buffer and presented downstream on a show-ahead valid/ready port.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (shared with the upstream pipeline)
//   bus     : pipe_drain_buffer_if.slave (launch, arrival, output, status)
// All outputs are registered; in_ready has no path from in_valid.
// -----------------------------------------------------------------------------
module pipe_drain_buffer
  import pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int LATENCY   = 5,
  parameter int DEPTH     = 8
) (
  input logic               clk,
  input logic               reset_n,
  pipe_drain_buffer_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH) + 32'sd1;

  localparam logic [LW-1:0] ZERO_LV  = {LW{1'b0}};
  localparam logic [LW-1:0] ONE_LV   = LW'(1'b1);
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [AW-1:0] ONE_AV   = AW'(1'b1);

  // The buffer is latency-agnostic: credits alone bound what can be in flight.
  logic unused_latency_s;
  assign unused_latency_s = (LATENCY >= 32'sd0);

  logic [LW-1:0]        credit_r, credit_nxt_s;
  logic [LW-1:0]        level_r, level_nxt_s, level_after_pop_s;
  logic [AW-1:0]        wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0]        rd_ptr_r, rd_ptr_nxt_s;
  logic                 in_ready_r, out_valid_r, overflow_r;
  logic [BIT_WIDTH-1:0] out_data_r, head_nxt_s, ram_rd_data_s;
  logic                 launch_s, pop_s, full_s, wr_en_s, drop_s;

  // Next-state decode for credits, pointers, level and the next head word.
  always_comb begin
    launch_s          = bus.in_valid & in_ready_r;
    pop_s             = out_valid_r & bus.out_ready;
    full_s            = (level_r == DEPTH_LV);
    // A pop in the same cycle frees the slot the arriving word needs.
    wr_en_s           = bus.pipe_valid & (~full_s | pop_s);
    drop_s            = bus.pipe_valid & full_s & ~pop_s;
    credit_nxt_s      = credit_r;
    level_nxt_s       = level_r;
    level_after_pop_s = level_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    head_nxt_s        = out_data_r;

    case ({launch_s, pop_s})
      2'b10:   credit_nxt_s = credit_r - ONE_LV;
      2'b01:   credit_nxt_s = credit_r + ONE_LV;
      default: credit_nxt_s = credit_r;
    endcase

    case ({wr_en_s, pop_s})
      2'b10:   level_nxt_s = level_r + ONE_LV;
      2'b01:   level_nxt_s = level_r - ONE_LV;
      default: level_nxt_s = level_r;
    endcase

    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ONE_AV;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s      = rd_ptr_r + ONE_AV;
      level_after_pop_s = level_r - ONE_LV;
    end else begin
      rd_ptr_nxt_s      = rd_ptr_r;
      level_after_pop_s = level_r;
    end

    // out_data is a register, so the next head is chosen here: hold when the
    // buffer will be empty, take the arriving word when it becomes the only
    // entry, otherwise read the stored entry at the advanced read pointer.
    if (level_nxt_s == ZERO_LV) begin
      head_nxt_s = out_data_r;
    end else if (level_after_pop_s == ZERO_LV) begin
      head_nxt_s = bus.pipe_data;
    end else begin
      head_nxt_s = ram_rd_data_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_r    <= DEPTH_LV;
      level_r     <= ZERO_LV;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      out_data_r  <= {BIT_WIDTH{1'b0}};
    end else begin
      credit_r    <= credit_nxt_s;
      level_r     <= level_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      in_ready_r  <= (credit_nxt_s != ZERO_LV);
      out_valid_r <= (level_nxt_s != ZERO_LV);
      overflow_r  <= overflow_r | drop_s;
      out_data_r  <= head_nxt_s;
    end
  end

  pipe_drain_ram #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.pipe_data),
    .rd_addr (rd_ptr_nxt_s),
    .rd_data (ram_rd_data_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.level     = level_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_drain_buffer
// Directed bench: an upstream driver with a 5-stage valid/data delay line feeds
// pipe_drain_buffer (BIT_WIDTH=8, LATENCY=5, DEPTH=8). Expected values are
// hand-derived per step.
// -----------------------------------------------------------------------------
module tb_pipe_drain_buffer;

  logic clk;
  logic reset_n;

  pipe_drain_buffer_if #(.BIT_WIDTH(8), .DEPTH(8)) bus ();

  pipe_drain_buffer #(
    .BIT_WIDTH (8),
    .LATENCY   (5),
    .DEPTH     (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pipe_drain_buffer_chk #(.DEPTH(8), .LATENCY(5)) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .launch  (bus.in_valid & bus.in_ready),
    .credit  (dut.credit_r),
    .level   (bus.level)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] in_data;
  logic       force_valid;
  logic [7:0] force_data;
  logic [4:0] dl_valid;
  logic [7:0] dl_data [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream model: fixed 5-stage pipeline sharing reset_n.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= 5'd0;
      for (int i = 0; i < 5; i++) dl_data[i] <= 8'd0;
    end else begin
      dl_valid <= {dl_valid[3:0], bus.in_valid & bus.in_ready};
      dl_data[0] <= in_data;
      for (int i = 1; i < 5; i++) dl_data[i] <= dl_data[i-1];
    end
  end

  always_comb begin
    bus.pipe_valid = dl_valid[4] | force_valid;
    bus.pipe_data  = force_valid ? force_data : dl_data[4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic toggle;
    logic launched;
    logic popped;

    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    in_data = 8'd0;
    force_valid = 1'b0;
    force_data = 8'd0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // 1. reset values
    chk("s1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("s1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s1_level", 32'(bus.level), 32'd0);
    chk("s1_overflow", 32'(bus.overflow), 32'd0);
    chk("s1_out_data", 32'(bus.out_data), 32'd0);

    // 2. eight launches with downstream stalled
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      in_data = 8'(i);
      chk("s2_in_ready_pre", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("s2_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("s2_level_early", 32'(bus.level), 32'd3);
    chk("s2_head", 32'(bus.out_data), 32'h00);
    repeat (4) tick();
    chk("s2_level_pre_full", 32'(bus.level), 32'd7);
    tick();
    chk("s2_level_full", 32'(bus.level), 32'd8);
    chk("s2_overflow", 32'(bus.overflow), 32'd0);
    chk("s2_in_ready_full", 32'(bus.in_ready), 32'd0);

    // 3. single pop from full, one refill launch
    chk("s3_head_before_pop", 32'(bus.out_data), 32'h00);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("s3_in_ready", 32'(bus.in_ready), 32'd1);
    chk("s3_level_after_pop", 32'(bus.level), 32'd7);
    chk("s3_head_after_pop", 32'(bus.out_data), 32'h01);
    bus.in_valid = 1'b1;
    in_data = 8'h08;
    tick();
    bus.in_valid = 1'b0;
    chk("s3_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (4) tick();
    chk("s3_level_pre_arrive", 32'(bus.level), 32'd7);
    tick();
    chk("s3_level_refull", 32'(bus.level), 32'd8);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("s3_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("s3_drain_order", 32'(bus.out_data), 32'(k));
      tick();
    end
    chk("s3_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("s3_empty_level", 32'(bus.level), 32'd0);
    chk("s3_empty_hold", 32'(bus.out_data), 32'h08);
    tick();
    chk("s3_empty_ignore_ready", 32'(bus.level), 32'd0);
    chk("s3_empty_hold2", 32'(bus.out_data), 32'h08);
    bus.out_ready = 1'b0;
    chk("s3_credit", 32'(dut.credit_r), 32'd8);

    // 4. stream 20 words with out_ready toggling 1,0,1,0
    sent = 0;
    recv = 0;
    cyc = 0;
    toggle = 1'b1;
    while (recv < 20 && cyc < 200) begin
      bus.in_valid = (sent < 20);
      in_data = 8'(8'h10 + sent);
      bus.out_ready = toggle;
      popped = bus.out_valid & toggle;
      if (popped) begin
        chk("s4_order", 32'(bus.out_data), 32'(8'h10 + recv));
      end
      chk("s4_level_bound", 32'(bus.level <= 4'd8), 32'd1);
      launched = bus.in_valid & bus.in_ready;
      tick();
      if (launched) sent++;
      if (popped) recv++;
      toggle = ~toggle;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("s4_received_all", 32'(recv), 32'd20);
    chk("s4_wr_ptr_wrap", 32'(dut.wr_ptr_r), 32'd5);
    chk("s4_rd_ptr_wrap", 32'(dut.rd_ptr_r), 32'd5);
    chk("s4_level_end", 32'(bus.level), 32'd0);
    chk("s4_out_valid_end", 32'(bus.out_valid), 32'd0);
    chk("s4_overflow", 32'(bus.overflow), 32'd0);

    // 5. forced arrival into a full buffer
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      in_data = 8'(8'h30 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("s5_level_full", 32'(bus.level), 32'd8);
    force_valid = 1'b1;
    force_data = 8'hAA;
    tick();
    force_valid = 1'b0;
    chk("s5_overflow_set", 32'(bus.overflow), 32'd1);
    chk("s5_level_kept", 32'(bus.level), 32'd8);
    chk("s5_head_kept", 32'(bus.out_data), 32'h30);
    repeat (3) tick();
    chk("s5_overflow_sticky", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("s5_drain_order", 32'(bus.out_data), 32'(8'h30 + k));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("s5_level_5", 32'(bus.level), 32'd5);
    chk("s5_head_after", 32'(bus.out_data), 32'h33);
    chk("s5_overflow_still", 32'(bus.overflow), 32'd1);
    bus.in_valid = 1'b1;
    in_data = 8'h40;
    tick();
    in_data = 8'h41;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("s5_level_inflight", 32'(bus.level), 32'd5);

    // 6. reset with level=5 and two words in flight
    reset_n = 1'b0;
    #1;
    chk("s6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("s6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_rst_level", 32'(bus.level), 32'd0);
    chk("s6_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("s6_rst_out_data", 32'(bus.out_data), 32'd0);
    tick();
    chk("s6_rst_hold_level", 32'(bus.level), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("s6_credit", 32'(dut.credit_r), 32'd8);
    chk("s6_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (6) tick();
    chk("s6_no_stale_arrival", 32'(bus.level), 32'd0);
    bus.in_valid = 1'b1;
    in_data = 8'h5C;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("s6_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s6_valid", 32'(bus.out_valid), 32'd1);
    chk("s6_data", 32'(bus.out_data), 32'h5C);
    chk("s6_level", 32'(bus.level), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("s6_level_end", 32'(bus.level), 32'd0);
    chk("s6_credit_end", 32'(dut.credit_r), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
